// File: rtl/duel_core.sv
// Two-player duel engine: lanes, armor, lives, aligned-fire hits, game-over FSM.
// Optional ARMOR_REGEN_EN adds per-ship armor regeneration after REGEN_CYC quiet cycles.
module duel_core #(
    parameter int NPOS     = 3,
    parameter int ARMOR    = 1,
    parameter int LIVES    = 3,
    parameter int COOLDOWN = 4,
`ifdef ARMOR_REGEN_EN
    parameter int REGEN_CYC = 16,
`endif
    localparam int PW = (NPOS > 1) ? $clog2(NPOS) : 1,
    localparam int LW = $clog2(LIVES + 1),
    localparam int AW = (ARMOR > 0) ? $clog2(ARMOR + 1) : 1
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          p1_left,
    input  logic          p1_right,
    input  logic          p1_fire,
    input  logic          p2_left,
    input  logic          p2_right,
    input  logic          p2_fire,
    input  logic          restart,
    output logic [PW-1:0] p1_pos,
    output logic [PW-1:0] p2_pos,
    output logic [AW-1:0] p1_armor,
    output logic [AW-1:0] p2_armor,
    output logic [LW-1:0] p1_lives,
    output logic [LW-1:0] p2_lives,
    output logic          aligned,
    output logic          hit_p1,
    output logic          hit_p2,
    output logic          done,
    output logic [1:0]    winner
);

    localparam int CW = $clog2(COOLDOWN + 1);
    localparam logic [PW-1:0] POS_INIT  = PW'(NPOS / 2);
    localparam logic [PW-1:0] POS_MAX   = PW'(NPOS - 1);
    localparam logic [AW-1:0] ARMOR_INIT = AW'(ARMOR);
    localparam logic [LW-1:0] LIVES_INIT = LW'(LIVES);
    localparam logic [CW-1:0] CD_INIT    = CW'(COOLDOWN);

    typedef enum logic [0:0] {PLAY, OVER} state_t;

    state_t        state, state_next;
    logic [CW-1:0] cooldown;
    logic          fire1_q, fire2_q;
    logic          edge1, edge2;
    logic          hit_on1, hit_on2;
    logic          kill1, kill2;

`ifdef ARMOR_REGEN_EN
    localparam int RW = $clog2(REGEN_CYC + 1);
    localparam logic [RW-1:0] REGEN_MAX = RW'(REGEN_CYC);
    logic [RW-1:0] regen1, regen2;
`endif

    function automatic logic [PW-1:0] move(input logic [PW-1:0] pos,
                                           input logic l, input logic r);
        logic [PW-1:0] res;
        res = pos;
        if (l && !r && pos != '0)
            res = pos - PW'(1);
        else if (r && !l && pos != POS_MAX)
            res = pos + PW'(1);
        return res;
    endfunction

    assign aligned = (p1_pos == p2_pos);
    assign edge1   = p1_fire & ~fire1_q;
    assign edge2   = p2_fire & ~fire2_q;

    // Simultaneous edges cancel; hits only land while aligned and out of cooldown.
    always_comb begin
        hit_on1 = 1'b0;
        hit_on2 = 1'b0;
        if (state == PLAY && cooldown == '0 && aligned) begin
            hit_on2 = edge1 & ~edge2;
            hit_on1 = edge2 & ~edge1;
        end
        kill1 = hit_on1 && p1_armor == '0 && p1_lives == LW'(1);
        kill2 = hit_on2 && p2_armor == '0 && p2_lives == LW'(1);
    end

    always_comb begin
        state_next = state;
        case (state)
            PLAY:    if (kill1 || kill2) state_next = OVER;
            OVER:    if (restart)        state_next = PLAY;
            default: state_next = PLAY;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) state <= PLAY;
        else     state <= state_next;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            p1_pos   <= POS_INIT;
            p2_pos   <= POS_INIT;
            p1_armor <= ARMOR_INIT;
            p2_armor <= ARMOR_INIT;
            p1_lives <= LIVES_INIT;
            p2_lives <= LIVES_INIT;
            hit_p1   <= 1'b0;
            hit_p2   <= 1'b0;
            done     <= 1'b0;
            winner   <= 2'b00;
            cooldown <= '0;
            fire1_q  <= 1'b0;
            fire2_q  <= 1'b0;
`ifdef ARMOR_REGEN_EN
            regen1   <= '0;
            regen2   <= '0;
`endif
        end else begin
            fire1_q <= p1_fire;
            fire2_q <= p2_fire;
            hit_p1  <= 1'b0;
            hit_p2  <= 1'b0;
            if (state == PLAY) begin
                p1_pos <= move(p1_pos, p1_left, p1_right);
                p2_pos <= move(p2_pos, p2_left, p2_right);
                if (cooldown != '0)
                    cooldown <= cooldown - CW'(1);
`ifdef ARMOR_REGEN_EN
                // Regen counts quiet PLAY cycles; a hit below overrides it.
                if (regen1 + RW'(1) == REGEN_MAX && p1_armor < ARMOR_INIT) begin
                    p1_armor <= p1_armor + AW'(1);
                    regen1   <= '0;
                end else if (regen1 != REGEN_MAX) begin
                    regen1 <= regen1 + RW'(1);
                end
                if (regen2 + RW'(1) == REGEN_MAX && p2_armor < ARMOR_INIT) begin
                    p2_armor <= p2_armor + AW'(1);
                    regen2   <= '0;
                end else if (regen2 != REGEN_MAX) begin
                    regen2 <= regen2 + RW'(1);
                end
`endif
                if (hit_on1) begin
                    hit_p1   <= 1'b1;
                    cooldown <= CD_INIT;
                    if (p1_armor != '0)      p1_armor <= p1_armor - AW'(1);
                    else if (p1_lives != '0) p1_lives <= p1_lives - LW'(1);
`ifdef ARMOR_REGEN_EN
                    regen1 <= '0;
`endif
                end
                if (hit_on2) begin
                    hit_p2   <= 1'b1;
                    cooldown <= CD_INIT;
                    if (p2_armor != '0)      p2_armor <= p2_armor - AW'(1);
                    else if (p2_lives != '0) p2_lives <= p2_lives - LW'(1);
`ifdef ARMOR_REGEN_EN
                    regen2 <= '0;
`endif
                end
                if (kill2) begin
                    done   <= 1'b1;
                    winner <= 2'b01;
                end else if (kill1) begin
                    done   <= 1'b1;
                    winner <= 2'b10;
                end
            end else if (restart) begin
                // Restart reloads everything except the fire edge registers.
                p1_pos   <= POS_INIT;
                p2_pos   <= POS_INIT;
                p1_armor <= ARMOR_INIT;
                p2_armor <= ARMOR_INIT;
                p1_lives <= LIVES_INIT;
                p2_lives <= LIVES_INIT;
                done     <= 1'b0;
                winner   <= 2'b00;
                cooldown <= '0;
`ifdef ARMOR_REGEN_EN
                regen1   <= '0;
                regen2   <= '0;
`endif
            end
        end
    end

endmodule

// File: doc/duel_core.md
Name: duel_core

Overview:
- Parametrised two-player duel engine for the Galaga game.
- Tracks each ship's lane, armor and lives, and detects firing while the two ships are aligned.
- Runs the game state machine through to game over and reports the winner.
- Sits between the debounced button inputs and the display/score driver, replacing the fixed 3-lane ship/armor/game logic.

Parameters:
- NPOS, 3: number of lanes per ship, minimum 2. PW = $clog2(NPOS).
- ARMOR, 1: armor units per ship at start. A hit consumes armor before lives.
- LIVES, 3: lives per ship at start, minimum 1. LW = $clog2(LIVES+1).
- COOLDOWN, 4: cycles after any applied hit during which both fire inputs are ignored, minimum 1. AW = $clog2(ARMOR+1).

Ports:
- CLK  in  1  clock
- RST  in  1  asynchronous reset, active-high
- p1_left, p1_right, p1_fire  in  1 each  player 1 controls, synchronous, level
- p2_left, p2_right, p2_fire  in  1 each  player 2 controls
- restart  in  1  start a new game from OVER
- p1_pos, p2_pos  out  PW  current lane, 0 = leftmost
- p1_armor, p2_armor  out  AW  remaining armor
- p1_lives, p2_lives  out  LW  remaining lives
- aligned  out  1  p1_pos == p2_pos (combinational from position registers)
- hit_p1, hit_p2  out  1  one-cycle pulse when that ship takes a hit
- done  out  1  high in OVER
- winner  out  2  00 none, 01 player 1, 10 player 2

Behaviour:
- Reset values:
  - positions = NPOS/2 (integer divide)
  - armor = ARMOR, lives = LIVES
  - hit pulses 0, done 0, winner 00, cooldown counter 0
  - fire edge registers 0
  - state PLAY
- Movement (PLAY only, every cycle, per ship):
  - left & ~right: decrement, saturating at 0.
  - right & ~left: increment, saturating at NPOS-1.
  - Both or neither: hold.
  - Moves apply in the same cycle as any hit evaluation and do not affect that evaluation, which uses pre-move positions.
- Fire:
  - Rising edge only: fire & ~fire_q, with fire_q registered every cycle in all states.
  - A held button fires once.
- Hit evaluation (PLAY, cooldown == 0, aligned):
  - p1 edge & ~p2 edge: hit on p2.
  - p2 edge & ~p1 edge: hit on p1.
  - Both edges in the same cycle: shots cancel, no hit, no cooldown.
  - Not aligned: edges discarded.
- Applying a hit to a ship:
  - If armor > 0, armor decrements.
  - Otherwise lives decrements.
  - hit_pX pulses for 1 cycle.
  - Cooldown loads COOLDOWN and counts down each cycle to 0. Edges seen while it is nonzero are discarded, not queued.
- State machine:
  - PLAY -> OVER on the cycle after a hit brings a ship's lives to 0.
  - On that transition, done=1 and winner = the opponent (01 if p2 lost, 10 if p1 lost).
  - Lives never underflow.
  - OVER: movement, fire and cooldown frozen; all outputs hold.
  - OVER & restart: reload all reset values except fire_q, then return to PLAY next cycle. restart is ignored in PLAY.
- RST mid-game: immediate asynchronous return to reset values regardless of state or cooldown.

Optional Feature:
- Macro ARMOR_REGEN_EN adds parameter REGEN_CYC (default 16).
- With ARMOR_REGEN_EN defined, per ship:
  - A regen counter counts PLAY cycles since that ship's last hit.
  - When it reaches REGEN_CYC and armor < ARMOR, armor increments by 1 and the counter clears.
  - The counter clears on a hit, reset or restart, and is frozen in OVER.
  - Armor saturates at ARMOR.
- Without the macro: no regen counters, armor only decreases, REGEN_CYC is absent.

Test Plan:
- Reset with defaults:
  - Required: p1_pos=p2_pos=1, aligned=1, armor=1, lives=3, done=0, winner=00.
- Movement saturation:
  - Stimulus: p1_left held 3 cycles.
  - Required: p1_pos 1->0->0->0. Then p1_left & p1_right held: p1_pos holds 0.
- Hit order:
  - Stimulus: aligned, p1_fire pulse.
  - Required: hit_p2 pulses 1 cycle, p2_armor=0, p2_lives=3.
  - Stimulus: second pulse 5 cycles later.
  - Required: p2_lives=2.
  - Stimulus: a pulse 2 cycles after a hit.
  - Required: ignored (cooldown).
- Simultaneous fire:
  - Stimulus: aligned, both fire edges in the same cycle.
  - Required: no hit pulses, armor and lives unchanged, next edge accepted immediately.
- Game over and restart:
  - Stimulus: p2 repeatedly hit by p1 until lives 0.
  - Required: next cycle done=1, winner=01, moves ignored.
  - Stimulus: restart=1.
  - Required: all values back to reset, PLAY.
- Async reset and optional regen:
  - Stimulus: RST asserted mid-cooldown.
  - Required: outputs reset without waiting for a clock edge.
  - With ARMOR_REGEN_EN and REGEN_CYC=16, stimulus: p1 hit to armor 0.
  - Required: p1_armor=1 after 16 PLAY cycles with no further hits.
